fpu_param: RTL and testbench

FPU_PARAM -- requirements
Module: fpu_param

---
 rtl/fpu_param.sv | 325 ++++++++++++++++++++++++++++++++
 tb/tb_fpu_param.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/fpu_param.sv
// Multi-cycle floating-point unit: add, sub, mul, div on sign/exponent/mantissa operands.
// Two's complement exponent, normalised mantissa (MSB=1), truncating arithmetic.
//
// state  | meaning
// IDLE   | ready, waiting for start
// CHECK  | classify operands, resolve special cases, set up datapath
// ALIGN  | shift smaller-exponent operand right
// ADDSUB | add/subtract magnitudes, first normalisation step
// NORM   | left-shift loop (add/sub), final select (mul/div)
// MULI   | shift-add multiply, MSB first
// DIVI   | restoring division step
// PACK   | range check, register result and flags
// DONE   | done pulse
module fpu_param #(
    parameter int EW = 7,
    parameter int MW = 15
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [1:0]    op,
    input  logic          a_s,
    input  logic [EW-1:0] a_e,
    input  logic [MW-1:0] a_m,
    input  logic          b_s,
    input  logic [EW-1:0] b_e,
    input  logic [MW-1:0] b_m,
    output logic          ready,
    output logic          done,
    output logic          res_s,
    output logic [EW-1:0] res_e,
    output logic [MW-1:0] res_m,
    output logic          zero_flag,
    output logic          inf_flag,
    output logic          overflow_flag,
    output logic          underflow_flag,
    output logic          div0_flag
);
    localparam int XW = EW + 2;
    localparam int CW = $clog2(MW + 1);
    localparam logic [EW-1:0] ZERO_E = {1'b1, {(EW-1){1'b0}}};
    localparam logic [EW-1:0] INF_E  = {1'b0, {(EW-1){1'b1}}};
    localparam logic [MW-1:0] MSB_M  = {1'b1, {(MW-1){1'b0}}};
    localparam logic signed [XW-1:0] ZERO_X = {2'b11, ZERO_E};
    localparam logic signed [XW-1:0] INF_X  = {2'b00, INF_E};
    localparam logic signed [XW-1:0] ONE_X  = 1;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    typedef enum logic [3:0] {
        S_IDLE, S_CHECK, S_ALIGN, S_ADDSUB, S_NORM, S_MULI, S_DIVI, S_PACK, S_DONE
    } state_t;

    state_t state;
    logic [1:0] op_r;
    logic as_r, bs_r;
    logic [EW-1:0] ae_r, be_r;
    logic [MW-1:0] am_r, bm_r;
    logic rs, special, fz, fi, fo, fu, fd, sl, ss;
    logic signed [XW-1:0] re;
    logic [MW-1:0] nm;
    logic [MW+1:0] xl, xs;
    logic [2*MW-1:0] prod;
    logic [MW:0] quo, rem;
    logic [CW-1:0] cnt;

    logic signed [XW-1:0] ae_x, be_x, ediff;
    logic a_inf, b_inf, a_zero, b_zero, a_big, bs_eff, inf_sign;
    logic [XW-1:0] shamt;
    logic [MW+1:0] small_full, small_sh, sum_raw, sum_sh1, xl_sh1;
    logic sum_s, mag_eq;
    logic [2*MW-1:0] prod_next;
    logic [MW:0] rem_sub;

    assign ae_x   = {{2{ae_r[EW-1]}}, ae_r};
    assign be_x   = {{2{be_r[EW-1]}}, be_r};
    assign a_inf  = (ae_r == INF_E);
    assign b_inf  = (be_r == INF_E);
    assign a_zero = (ae_r == ZERO_E);
    assign b_zero = (be_r == ZERO_E);
    assign bs_eff = bs_r ^ op_r[0];
    assign inf_sign = op_r[1] ? (as_r ^ bs_r) : (a_inf ? as_r : bs_eff);

    assign ediff      = ae_x - be_x;
    assign a_big      = !ediff[XW-1];
    assign shamt      = a_big ? ediff : -ediff;
    assign small_full = {1'b0, (a_big ? bm_r : am_r), 1'b0};
    assign small_sh   = (shamt > XW'(MW + 1)) ? '0 : (small_full >> shamt);

    always_comb begin
        sum_raw = '0;
        sum_s   = 1'b0;
        mag_eq  = 1'b0;
        if (sl == ss) begin
            sum_raw = xl + xs;
            sum_s   = sl;
        end else if (xl > xs) begin
            sum_raw = xl - xs;
            sum_s   = sl;
        end else if (xs > xl) begin
            sum_raw = xs - xl;
            sum_s   = ss;
        end else begin
            mag_eq = 1'b1;
        end
    end

    assign sum_sh1   = sum_raw << 1;
    assign xl_sh1    = xl << 1;
    assign prod_next = (prod << 1) + (bm_r[cnt] ? {{MW{1'b0}}, am_r} : '0);
    assign rem_sub   = rem - {1'b0, bm_r};

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            ready <= 1'b1;
            done  <= 1'b0;
            res_s <= 1'b0;
            res_e <= '0;
            res_m <= '0;
            zero_flag <= 1'b0;
            inf_flag <= 1'b0;
            overflow_flag <= 1'b0;
            underflow_flag <= 1'b0;
            div0_flag <= 1'b0;
            op_r <= '0;
            as_r <= 1'b0;
            bs_r <= 1'b0;
            ae_r <= '0;
            be_r <= '0;
            am_r <= '0;
            bm_r <= '0;
            rs <= 1'b0;
            special <= 1'b0;
            fz <= 1'b0;
            fi <= 1'b0;
            fo <= 1'b0;
            fu <= 1'b0;
            fd <= 1'b0;
            sl <= 1'b0;
            ss <= 1'b0;
            re <= '0;
            nm <= '0;
            xl <= '0;
            xs <= '0;
            prod <= '0;
            quo <= '0;
            rem <= '0;
            cnt <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: if (start) begin
                    op_r <= op;
                    as_r <= a_s;
                    ae_r <= a_e;
                    am_r <= a_m;
                    bs_r <= b_s;
                    be_r <= b_e;
                    bm_r <= b_m;
                    ready <= 1'b0;
                    state <= S_CHECK;
                end
                S_CHECK: begin
                    special <= 1'b1;
                    {fz, fi, fo, fu, fd} <= '0;
                    rs <= as_r ^ bs_r;
                    nm <= MSB_M;
                    state <= S_PACK;
                    if (op_r == OP_DIV && b_zero) begin
                        re <= INF_X;
                        fd <= 1'b1;
                    end else if (a_inf || b_inf) begin
                        rs <= inf_sign;
                        re <= INF_X;
                        fi <= 1'b1;
                    end else if ((op_r == OP_MUL && (a_zero || b_zero)) ||
                                 (op_r == OP_DIV && a_zero) || (a_zero && b_zero)) begin
                        rs <= 1'b0;
                        re <= ZERO_X;
                        fz <= 1'b1;
                    end else if (!op_r[1] && a_zero) begin
                        rs <= bs_eff;
                        re <= be_x;
                        nm <= bm_r;
                    end else if (!op_r[1] && b_zero) begin
                        rs <= as_r;
                        re <= ae_x;
                        nm <= am_r;
                    end else begin
                        special <= 1'b0;
                        case (op_r)
                            OP_MUL: begin
                                re <= ae_x + be_x;
                                prod <= '0;
                                cnt <= CW'(MW - 1);
                                state <= S_MULI;
                            end
                            OP_DIV: begin
                                re <= ae_x - be_x;
                                rem <= {1'b0, am_r};
                                quo <= '0;
                                cnt <= CW'(MW);
                                state <= S_DIVI;
                            end
                            default: state <= S_ALIGN;
                        endcase
                    end
                end
                S_ALIGN: begin
                    re <= a_big ? ae_x : be_x;
                    xl <= {1'b0, (a_big ? am_r : bm_r), 1'b0};
                    xs <= small_sh;
                    sl <= a_big ? as_r : bs_eff;
                    ss <= a_big ? bs_eff : as_r;
                    state <= S_ADDSUB;
                end
                S_ADDSUB: begin
                    rs <= sum_s;
                    state <= S_PACK;
                    if (mag_eq) begin
                        special <= 1'b1;
                        fz <= 1'b1;
                        re <= ZERO_X;
                        nm <= MSB_M;
                    end else if (sum_raw[MW+1]) begin
                        nm <= sum_raw[MW+1:2];
                        re <= re + ONE_X;
                    end else if (sum_raw[MW]) begin
                        nm <= sum_raw[MW:1];
                    end else begin
                        // first left shift folded in here; NORM continues if needed
                        re <= re - ONE_X;
                        if (sum_sh1[MW]) begin
                            nm <= sum_sh1[MW:1];
                        end else begin
                            xl <= sum_sh1;
                            state <= S_NORM;
                        end
                    end
                end
                S_NORM: begin
                    state <= S_PACK;
                    case (op_r)
                        OP_MUL: begin
                            if (prod[2*MW-1]) begin
                                nm <= prod[2*MW-1:MW];
                                re <= re + ONE_X;
                            end else begin
                                nm <= prod[2*MW-2:MW-1];
                            end
                        end
                        OP_DIV: begin
                            if (quo[MW]) begin
                                nm <= quo[MW:1];
                            end else begin
                                nm <= quo[MW-1:0];
                                re <= re - ONE_X;
                            end
                        end
                        default: begin
                            re <= re - ONE_X;
                            if (xl_sh1[MW]) begin
                                nm <= xl_sh1[MW:1];
                            end else begin
                                xl <= xl_sh1;
                                state <= S_NORM;
                            end
                        end
                    endcase
                end
                S_MULI: begin
                    prod <= prod_next;
                    if (cnt == '0) state <= S_NORM;
                    else cnt <= cnt - 1'b1;
                end
                S_DIVI: begin
                    if (rem >= {1'b0, bm_r}) begin
                        quo <= {quo[MW-1:0], 1'b1};
                        rem <= rem_sub << 1;
                    end else begin
                        quo <= {quo[MW-1:0], 1'b0};
                        rem <= rem << 1;
                    end
                    if (cnt == '0) state <= S_NORM;
                    else cnt <= cnt - 1'b1;
                end
                S_PACK: begin
                    if (special) begin
                        res_s <= rs;
                        res_e <= re[EW-1:0];
                        res_m <= nm;
                        {zero_flag, inf_flag, overflow_flag, underflow_flag, div0_flag} <=
                            {fz, fi, fo, fu, fd};
                    end else if (re >= INF_X) begin
                        res_s <= rs;
                        res_e <= INF_E;
                        res_m <= MSB_M;
                        {zero_flag, inf_flag, overflow_flag, underflow_flag, div0_flag} <= 5'b01100;
                    end else if (re <= ZERO_X) begin
                        res_s <= 1'b0;
                        res_e <= ZERO_E;
                        res_m <= MSB_M;
                        {zero_flag, inf_flag, overflow_flag, underflow_flag, div0_flag} <= 5'b10010;
                    end else begin
                        res_s <= rs;
                        res_e <= re[EW-1:0];
                        res_m <= nm;
                        {zero_flag, inf_flag, overflow_flag, underflow_flag, div0_flag} <= '0;
                    end
                    done <= 1'b1;
                    state <= S_DONE;
                end
                S_DONE: begin
                    ready <= 1'b1;
                    state <= S_IDLE;
                end
                default: begin
                    ready <= 1'b1;
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fpu_param.sv
// Scoreboard bench for fpu_param (EW=7, MW=15): directed vectors with hand-computed results,
// checked for value, flags and done latency by an independent monitor.
module tb_fpu_param;
    logic clk = 1'b0;
    logic reset, start;
    logic [1:0] op;
    logic a_s, b_s;
    logic [6:0] a_e, b_e;
    logic [14:0] a_m, b_m;
    logic ready, done, res_s;
    logic [6:0] res_e;
    logic [14:0] res_m;
    logic zero_flag, inf_flag, overflow_flag, underflow_flag, div0_flag;

    fpu_param #(.EW(7), .MW(15)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .a_s(a_s), .a_e(a_e), .a_m(a_m), .b_s(b_s), .b_e(b_e), .b_m(b_m),
        .ready(ready), .done(done), .res_s(res_s), .res_e(res_e), .res_m(res_m),
        .zero_flag(zero_flag), .inf_flag(inf_flag), .overflow_flag(overflow_flag),
        .underflow_flag(underflow_flag), .div0_flag(div0_flag)
    );

    always #5 clk = ~clk;

    typedef struct {
        string name;
        logic [27:0] res;
        int lat;
        int t0;
    } exp_t;

    exp_t q[$];
    int cyc = 0;
    int n_cmp = 0;
    int n_err = 0;

    always @(posedge clk) cyc++;

    // {s, e, m, zero, inf, ovf, unf, div0}
    function automatic logic [27:0] mk(logic s, logic [6:0] e, logic [14:0] m, logic [4:0] f);
        return {s, e, m, f};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, expv);
        end
    endtask

    always begin
        @(posedge clk);
        #1;
        if (done) begin
            if (q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_done: got done=1 expected no result pending");
            end else begin
                exp_t e;
                e = q.pop_front();
                chk(e.name, {4'b0, res_s, res_e, res_m, zero_flag, inf_flag, overflow_flag,
                    underflow_flag, div0_flag}, {4'b0, e.res});
                chk({e.name, "_latency"}, cyc - e.t0, e.lat);
            end
        end
    end

    task automatic drive(input logic [1:0] o, input logic as, input logic [6:0] ae,
                         input logic [14:0] am, input logic bs, input logic [6:0] be,
                         input logic [14:0] bm);
        op = o; a_s = as; a_e = ae; a_m = am; b_s = bs; b_e = be; b_m = bm;
    endtask

    task automatic issue(input string nm, input logic [1:0] o, input logic as,
                         input logic [6:0] ae, input logic [14:0] am, input logic bs,
                         input logic [6:0] be, input logic [14:0] bm,
                         input logic [27:0] expr, input int lat);
        int w;
        exp_t e;
        w = 0;
        while (!ready && w < 100) begin
            @(posedge clk);
            #1;
            w++;
        end
        if (!ready) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s_ready_timeout: got ready=0 expected ready=1", nm);
            return;
        end
        drive(o, as, ae, am, bs, be, bm);
        start = 1'b1;
        e.name = nm;
        e.res = expr;
        e.lat = lat;
        e.t0 = cyc;
        q.push_back(e);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int w;
        w = 0;
        while ((q.size() != 0 || !ready) && w < 200) begin
            @(posedge clk);
            #1;
            w++;
        end
        if (q.size() != 0 || !ready) begin
            n_cmp++;
            n_err++;
            $display("FAIL idle_timeout: got pending=%0d expected 0", q.size());
            q.delete();
        end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        drive(2'b00, 1'b0, 7'h0, 15'h0, 1'b0, 7'h0, 15'h0);
        repeat (2) @(posedge clk);
        #1;
        chk("reset_ready_done", {30'b0, ready, done}, 32'h2);
        chk("reset_outputs", {4'b0, res_s, res_e, res_m, zero_flag, inf_flag, overflow_flag,
            underflow_flag, div0_flag}, 32'h0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("ready_after_reset", {31'b0, ready}, 32'h1);

        issue("add_1p1",      2'b00, 0, 7'h00, 15'h4000, 0, 7'h00, 15'h4000, mk(0, 7'h01, 15'h4000, 5'b00000), 5);
        issue("sub_1m1",      2'b01, 0, 7'h00, 15'h4000, 0, 7'h00, 15'h4000, mk(0, 7'h40, 15'h4000, 5'b10000), 5);
        issue("sub_1m075",    2'b01, 0, 7'h00, 15'h4000, 0, 7'h7F, 15'h6000, mk(0, 7'h7E, 15'h4000, 5'b00000), 6);
        issue("add_mixsign",  2'b00, 0, 7'h00, 15'h6000, 1, 7'h7F, 15'h4000, mk(0, 7'h00, 15'h4000, 5'b00000), 5);
        issue("add_bigdiff",  2'b00, 0, 7'h00, 15'h4000, 0, 7'h6C, 15'h7FFF, mk(0, 7'h00, 15'h4000, 5'b00000), 5);
        issue("add_ovf",      2'b00, 0, 7'h3E, 15'h4000, 0, 7'h3E, 15'h4000, mk(0, 7'h3F, 15'h4000, 5'b01100), 5);
        issue("mul_15x15",    2'b10, 0, 7'h00, 15'h6000, 0, 7'h00, 15'h6000, mk(0, 7'h01, 15'h4800, 5'b00000), 19);
        issue("mul_1x1",      2'b10, 0, 7'h00, 15'h4000, 1, 7'h00, 15'h4000, mk(1, 7'h00, 15'h4000, 5'b00000), 19);
        issue("mul_ovf",      2'b10, 0, 7'h3E, 15'h4000, 0, 7'h3E, 15'h4000, mk(0, 7'h3F, 15'h4000, 5'b01100), 19);
        issue("mul_unf",      2'b10, 0, 7'h44, 15'h4000, 0, 7'h44, 15'h4000, mk(0, 7'h40, 15'h4000, 5'b10010), 19);
        issue("mul_zero",     2'b10, 1, 7'h00, 15'h4000, 0, 7'h40, 15'h4000, mk(0, 7'h40, 15'h4000, 5'b10000), 3);
        issue("div_6d2",      2'b11, 0, 7'h02, 15'h6000, 0, 7'h01, 15'h4000, mk(0, 7'h01, 15'h6000, 5'b00000), 20);
        issue("div_1d15",     2'b11, 1, 7'h00, 15'h4000, 0, 7'h00, 15'h6000, mk(1, 7'h7F, 15'h5555, 5'b00000), 20);
        issue("div_by0",      2'b11, 0, 7'h00, 15'h4000, 0, 7'h40, 15'h4000, mk(0, 7'h3F, 15'h4000, 5'b00001), 3);
        issue("add_inf",      2'b00, 0, 7'h3F, 15'h4000, 0, 7'h00, 15'h4000, mk(0, 7'h3F, 15'h4000, 5'b01000), 3);
        issue("sub_bzero",    2'b01, 0, 7'h00, 15'h4000, 0, 7'h40, 15'h4000, mk(0, 7'h00, 15'h4000, 5'b00000), 3);
        issue("sub_azero",    2'b01, 0, 7'h40, 15'h4000, 0, 7'h00, 15'h4000, mk(1, 7'h00, 15'h4000, 5'b00000), 3);

        // start while busy must be ignored
        issue("mul_busy",     2'b10, 1, 7'h00, 15'h6000, 0, 7'h00, 15'h6000, mk(1, 7'h01, 15'h4800, 5'b00000), 19);
        repeat (3) @(posedge clk);
        #1;
        drive(2'b00, 0, 7'h05, 15'h7000, 0, 7'h03, 15'h5000);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_idle();

        // reset in the middle of a multiply
        drive(2'b10, 0, 7'h00, 15'h6000, 0, 7'h00, 15'h6000);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("midreset_ready_done", {30'b0, ready, done}, 32'h2);
        chk("midreset_outputs", {4'b0, res_s, res_e, res_m, zero_flag, inf_flag, overflow_flag,
            underflow_flag, div0_flag}, 32'h0);
        reset = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        chk("midreset_ready_idle", {31'b0, ready}, 32'h1);

        issue("add_recover",  2'b00, 0, 7'h00, 15'h4000, 0, 7'h00, 15'h4000, mk(0, 7'h01, 15'h4000, 5'b00000), 5);
        wait_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
